// File: rtl/edgedrnn_pkg.sv
// Shared types and default sizing for the edgedrnn timestep sequencer.
package edgedrnn_pkg;

  // Sequencer states: idle, streaming an input frame, collecting the
  // matching output frame, and the one-cycle completion state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    WAIT_OUT = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_PE     = 8;
  localparam int DEF_ACT_INT_BW = 8;
  localparam int DEF_ACT_FRA_BW = 8;
  localparam int ACT_BW         = DEF_ACT_INT_BW + DEF_ACT_FRA_BW;
  localparam int DEF_BEATS_BW   = 8;
  localparam int DEF_SEQ_LEN_BW = 16;
  localparam int DEF_DW         = DEF_NUM_PE * ACT_BW;

  // Width of one stream beat: every lane carries one activation.
  function automatic int beat_width(input int num_pe, input int act_int_bw,
                                    input int act_fra_bw);
    return num_pe * (act_int_bw + act_fra_bw);
  endfunction

endpackage

// File: rtl/edgedrnn_seq_ctrl_if.sv
// AXI-Stream style bundle used for all four sequencer streams.
interface edgedrnn_seq_ctrl_if
  import edgedrnn_pkg::*;
#(
  parameter int DW = DEF_DW
) ();

  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  // Source side drives valid/data/last and listens to ready.
  modport master (output tvalid, output tdata, output tlast, input tready);

  // Sink side listens to valid/data/last and drives ready.
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/edgedrnn_frame_cnt.sv
// Beat counter for one frame: counts accepted beats and flags the final
// beat of the frame so tlast can be regenerated from the configured length.
module edgedrnn_frame_cnt
  import edgedrnn_pkg::*;
#(
  parameter int W = DEF_BEATS_BW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] beats,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Terminal count: the current beat is the final one of the frame.
  always_comb begin
    last = (cnt_q == (beats - W'(1)));
  end

  // Clear wins over counting; the counter wraps to zero after the final beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/edgedrnn_seq_ctrl.sv
// Timestep sequencer in front of the edgedrnn core. Streams one host input
// frame into the core, then forwards the matching core output frame back to
// the host, repeating for the configured number of timesteps.
module edgedrnn_seq_ctrl
  import edgedrnn_pkg::*;
#(
  parameter int NUM_PE     = DEF_NUM_PE,
  parameter int ACT_INT_BW = DEF_ACT_INT_BW,
  parameter int ACT_FRA_BW = DEF_ACT_FRA_BW,
  parameter int BEATS_BW   = DEF_BEATS_BW,
  parameter int SEQ_LEN_BW = DEF_SEQ_LEN_BW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [BEATS_BW-1:0]   cfg_inp_beats,
  input  logic [BEATS_BW-1:0]   cfg_out_beats,
  input  logic [SEQ_LEN_BW-1:0] cfg_seq_len,
  output logic                  busy,
  output logic                  done,
  output logic [SEQ_LEN_BW-1:0] ts_cnt,
  output logic                  err_cfg,
  output logic                  err_tlast,
  edgedrnn_seq_ctrl_if.slave    s_host,
  edgedrnn_seq_ctrl_if.master   m_inp,
  edgedrnn_seq_ctrl_if.slave    s_out,
  edgedrnn_seq_ctrl_if.master   m_host
);

  localparam int DW = beat_width(NUM_PE, ACT_INT_BW, ACT_FRA_BW);

  seq_state_t state_q, state_d;

  logic [BEATS_BW-1:0]   inp_beats_q, inp_beats_d;
  logic [BEATS_BW-1:0]   out_beats_q, out_beats_d;
  logic [SEQ_LEN_BW-1:0] seq_len_q, seq_len_d;
  logic [SEQ_LEN_BW-1:0] ts_cnt_q, ts_cnt_d;
  logic                  err_cfg_q, err_cfg_d;
  logic                  err_tlast_q, err_tlast_d;

  logic                  in_clr, in_en, in_last;
  logic                  out_clr, out_en, out_last;
  logic [BEATS_BW-1:0]   in_cnt, out_cnt;
  logic                  cfg_ok;
  logic                  in_hs, out_hs;
  logic [SEQ_LEN_BW:0]   ts_next_ext;

  edgedrnn_frame_cnt #(.W(BEATS_BW)) u_in_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_clr),
    .en    (in_en),
    .beats (inp_beats_q),
    .cnt   (in_cnt),
    .last  (in_last)
  );

  edgedrnn_frame_cnt #(.W(BEATS_BW)) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (out_clr),
    .en    (out_en),
    .beats (out_beats_q),
    .cnt   (out_cnt),
    .last  (out_last)
  );

  // Start qualification and timestep arithmetic; the extra bit keeps a
  // maximum-length sequence from wrapping before it is compared.
  always_comb begin
    cfg_ok      = (cfg_inp_beats != '0) && (cfg_out_beats != '0) && (cfg_seq_len != '0);
    ts_next_ext = {1'b0, ts_cnt_q} + (SEQ_LEN_BW + 1)'(1);
    in_hs       = (state_q == FEED) && s_host.tvalid && m_inp.tready;
    out_hs      = (state_q == WAIT_OUT) && s_out.tvalid && m_host.tready;
  end

  // Next-state logic, stream gating and sticky flags; abort overrides
  // everything else including a last-beat handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    inp_beats_d = inp_beats_q;
    out_beats_d = out_beats_q;
    seq_len_d   = seq_len_q;
    ts_cnt_d    = ts_cnt_q;
    err_cfg_d   = err_cfg_q;
    err_tlast_d = err_tlast_q;
    in_clr      = 1'b0;
    in_en       = 1'b0;
    out_clr     = 1'b0;
    out_en      = 1'b0;

    m_inp.tvalid  = 1'b0;
    m_inp.tdata   = s_host.tdata;
    m_inp.tlast   = 1'b0;
    s_host.tready = 1'b0;
    m_host.tvalid = 1'b0;
    m_host.tdata  = s_out.tdata;
    m_host.tlast  = 1'b0;
    s_out.tready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            inp_beats_d = cfg_inp_beats;
            out_beats_d = cfg_out_beats;
            seq_len_d   = cfg_seq_len;
            ts_cnt_d    = '0;
            err_tlast_d = 1'b0;
            err_cfg_d   = 1'b0;
            in_clr      = 1'b1;
            out_clr     = 1'b1;
            state_d     = FEED;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end

      FEED: begin
        m_inp.tvalid  = s_host.tvalid;
        s_host.tready = m_inp.tready;
        m_inp.tlast   = in_last;
        if (in_hs) begin
          in_en = 1'b1;
          if (s_host.tlast != in_last) begin
            err_tlast_d = 1'b1;
          end
          if (in_last) begin
            state_d = WAIT_OUT;
          end
        end
      end

      WAIT_OUT: begin
        m_host.tvalid = s_out.tvalid;
        s_out.tready  = m_host.tready;
        m_host.tlast  = out_last;
        if (out_hs) begin
          out_en = 1'b1;
          if (s_out.tlast != out_last) begin
            err_tlast_d = 1'b1;
          end
          if (out_last) begin
            ts_cnt_d = ts_next_ext[SEQ_LEN_BW-1:0];
            if (ts_next_ext == {1'b0, seq_len_q}) begin
              state_d = DONE;
            end else begin
              state_d = FEED;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (cfg_abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      ts_cnt_d = ts_cnt_q;
      in_en    = 1'b0;
      out_en   = 1'b0;
      in_clr   = 1'b1;
      out_clr  = 1'b1;
    end
  end

  // State, latched configuration, timestep count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inp_beats_q <= '0;
      out_beats_q <= '0;
      seq_len_q   <= '0;
      ts_cnt_q    <= '0;
      err_cfg_q   <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inp_beats_q <= inp_beats_d;
      out_beats_q <= out_beats_d;
      seq_len_q   <= seq_len_d;
      ts_cnt_q    <= ts_cnt_d;
      err_cfg_q   <= err_cfg_d;
      err_tlast_q <= err_tlast_d;
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy      = (state_q == FEED) || (state_q == WAIT_OUT);
    done      = (state_q == DONE);
    ts_cnt    = ts_cnt_q;
    err_cfg   = err_cfg_q;
    err_tlast = err_tlast_q;
  end

endmodule

// File: tb/tb_edgedrnn_seq_ctrl.sv
// Self-checking bench for the edgedrnn timestep sequencer. The bench plays
// host and core on all four streams and predicts behaviour from frame
// arithmetic (beats accepted, frames completed) rather than from states.
module tb_edgedrnn_seq_ctrl;
  import edgedrnn_pkg::*;

  localparam int DW         = 128;
  localparam int BEATS_BW   = 8;
  localparam int SEQ_LEN_BW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_start;
  logic                  cfg_abort;
  logic [BEATS_BW-1:0]   cfg_inp_beats;
  logic [BEATS_BW-1:0]   cfg_out_beats;
  logic [SEQ_LEN_BW-1:0] cfg_seq_len;
  logic                  busy;
  logic                  done;
  logic [SEQ_LEN_BW-1:0] ts_cnt;
  logic                  err_cfg;
  logic                  err_tlast;

  int checks = 0;
  int errors = 0;

  edgedrnn_seq_ctrl_if #(.DW(DW)) s_host_if ();
  edgedrnn_seq_ctrl_if #(.DW(DW)) m_inp_if ();
  edgedrnn_seq_ctrl_if #(.DW(DW)) s_out_if ();
  edgedrnn_seq_ctrl_if #(.DW(DW)) m_host_if ();

  edgedrnn_seq_ctrl #(
    .NUM_PE     (8),
    .ACT_INT_BW (8),
    .ACT_FRA_BW (8),
    .BEATS_BW   (BEATS_BW),
    .SEQ_LEN_BW (SEQ_LEN_BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_inp_beats (cfg_inp_beats),
    .cfg_out_beats (cfg_out_beats),
    .cfg_seq_len   (cfg_seq_len),
    .busy          (busy),
    .done          (done),
    .ts_cnt        (ts_cnt),
    .err_cfg       (err_cfg),
    .err_tlast     (err_tlast),
    .s_host        (s_host_if),
    .m_inp         (m_inp_if),
    .s_out         (s_out_if),
    .m_host        (m_host_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] randBeat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives every bench-side stream signal to one level.
  task automatic driveStreams(input logic v);
    s_host_if.tvalid = v;
    s_host_if.tdata  = '0;
    s_host_if.tlast  = 1'b0;
    m_inp_if.tready  = v;
    s_out_if.tvalid  = v;
    s_out_if.tdata   = '0;
    s_out_if.tlast   = 1'b0;
    m_host_if.tready = v;
  endtask

  // All gated stream outputs must be idle (IDLE, DONE or reset).
  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_s_host_tready"}, s_host_if.tready, 1'b0);
    checkOutput({tag, "_m_inp_tvalid"}, m_inp_if.tvalid, 1'b0);
    checkOutput({tag, "_s_out_tready"}, s_out_if.tready, 1'b0);
    checkOutput({tag, "_m_host_tvalid"}, m_host_if.tvalid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  // Runs one sequence with optional stalls, a corrupted host tlast, an abort
  // after a given number of output beats, or a reset after a given number of
  // input beats. Negative indices disable the corresponding event.
  task automatic applyStimulus(input int ibeats, input int obeats, input int slen,
                               input bit stall, input int bad_beat,
                               input int abort_out, input int reset_in);
    logic [DW-1:0] host_data[$];
    logic          host_tl[$];
    logic [DW-1:0] core_q[$];
    logic [DW-1:0] exp_out[$];
    int  in_done, out_done, frames, cyc;
    bit  host_pres, core_pres, err_exp, running, fin, first;
    bit  feeding, hs_in, hs_out, abort_now, exp_tl;

    for (int i = 0; i < slen * ibeats; i++) begin
      host_data.push_back(randBeat());
      exp_tl = ((i % ibeats) == ibeats - 1);
      host_tl.push_back((i == bad_beat) ? !exp_tl : exp_tl);
    end
    in_done = 0; out_done = 0; frames = 0; cyc = 0;
    host_pres = 0; core_pres = 0; err_exp = 0; fin = 0; first = 1;

    driveStreams(1'b0);
    cfg_inp_beats = BEATS_BW'(ibeats);
    cfg_out_beats = BEATS_BW'(obeats);
    cfg_seq_len   = SEQ_LEN_BW'(slen);
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    running   = 1;
    // Configuration inputs are not meant to matter once the run has started.
    cfg_inp_beats = BEATS_BW'($urandom);
    cfg_out_beats = BEATS_BW'($urandom);
    cfg_seq_len   = SEQ_LEN_BW'($urandom);

    while (!fin && cyc < 3000) begin
      cyc++;
      feeding = (in_done < (frames + 1) * ibeats);

      if (reset_in >= 0 && feeding && in_done == reset_in) begin
        driveStreams(1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ts_cnt", ts_cnt, '0);
        checkOutput("rst_err_cfg", err_cfg, 1'b0);
        checkOutput("rst_err_tlast", err_tlast, 1'b0);
        checkQuiet("rst");
        @(negedge clk);
        checkQuiet("rst_hold");
        rst_n = 1'b1;
        driveStreams(1'b0);
        @(negedge clk);
        checkOutput("rst_rel_ts_cnt", ts_cnt, '0);
        checkOutput("rst_rel_done", done, 1'b0);
        checkQuiet("rst_rel");
        return;
      end

      if (!host_pres && in_done < host_data.size() && (!stall || $urandom_range(0, 9) < 6))
        host_pres = 1;
      if (!core_pres && core_q.size() > 0 && (!stall || $urandom_range(0, 9) < 6))
        core_pres = 1;
      s_host_if.tvalid = host_pres;
      s_host_if.tdata  = host_pres ? host_data[in_done] : '0;
      s_host_if.tlast  = host_pres ? host_tl[in_done] : 1'b0;
      m_inp_if.tready  = !stall || ($urandom_range(0, 9) < 6);
      s_out_if.tvalid  = core_pres;
      s_out_if.tdata   = core_pres ? core_q[0] : '0;
      s_out_if.tlast   = core_pres ? ((out_done % obeats) == obeats - 1) : 1'b0;
      m_host_if.tready = !stall || ($urandom_range(0, 9) < 6);
      cfg_start        = ($urandom_range(0, 7) == 0);

      abort_now = (abort_out >= 0) && !feeding && (out_done == abort_out);
      if (abort_now) begin
        cfg_abort        = 1'b1;
        m_host_if.tready = 1'b0;
      end

      @(negedge clk);
      if (first) begin
        checkOutput("start_err_cfg", err_cfg, 1'b0);
        checkOutput("start_err_tlast", err_tlast, 1'b0);
        checkOutput("start_ts_cnt", ts_cnt, '0);
        first = 0;
      end
      checkOutput("m_inp_tvalid", m_inp_if.tvalid, running && feeding && s_host_if.tvalid);
      checkOutput("s_host_tready", s_host_if.tready, running && feeding && m_inp_if.tready);
      checkOutput("m_host_tvalid", m_host_if.tvalid, running && !feeding && s_out_if.tvalid);
      checkOutput("s_out_tready", s_out_if.tready, running && !feeding && m_host_if.tready);
      checkOutput("busy", busy, 1'b1);
      checkOutput("done_early", done, 1'b0);
      checkOutput("ts_cnt", ts_cnt, SEQ_LEN_BW'(frames));

      hs_in  = feeding && s_host_if.tvalid && m_inp_if.tready;
      hs_out = !feeding && s_out_if.tvalid && m_host_if.tready;
      if (hs_in) begin
        exp_tl = ((in_done % ibeats) == ibeats - 1);
        checkOutput("m_inp_tdata", m_inp_if.tdata, host_data[in_done]);
        checkOutput("m_inp_tlast", m_inp_if.tlast, exp_tl);
        if (host_tl[in_done] != exp_tl) err_exp = 1;
        if ((in_done % ibeats) == 0) begin
          for (int k = 0; k < obeats; k++) begin
            core_q.push_back(randBeat());
            exp_out.push_back(core_q[core_q.size() - 1]);
          end
        end
      end
      if (hs_out) begin
        checkOutput("m_host_tdata", m_host_if.tdata, exp_out[out_done]);
        checkOutput("m_host_tlast", m_host_if.tlast, (out_done % obeats) == obeats - 1);
      end

      @(posedge clk); #1;
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
      if (hs_in) begin
        in_done++;
        host_pres = 0;
      end
      if (hs_out) begin
        out_done++;
        void'(core_q.pop_front());
        core_pres = 0;
        if ((out_done % obeats) == 0) frames++;
      end

      if (abort_now) begin
        driveStreams(1'b1);
        @(negedge clk);
        checkQuiet("abort");
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_ts_cnt", ts_cnt, SEQ_LEN_BW'(frames));
        driveStreams(1'b0);
        @(posedge clk); #1;
        return;
      end
      if (frames == slen) fin = 1;
    end

    if (!fin) begin
      checkOutput("timeout", 1'b0, 1'b1);
      return;
    end
    driveStreams(1'b1);
    @(negedge clk);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_ts_cnt", ts_cnt, SEQ_LEN_BW'(slen));
    checkOutput("done_err_tlast", err_tlast, err_exp);
    checkQuiet("done");
    @(negedge clk);
    checkOutput("done_once", done, 1'b0);
    checkOutput("idle_ts_cnt", ts_cnt, SEQ_LEN_BW'(slen));
    checkQuiet("idle");
    driveStreams(1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_abort     = 1'b0;
    cfg_inp_beats = '0;
    cfg_out_beats = '0;
    cfg_seq_len   = '0;
    driveStreams(1'b1);
    #2;
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_ts_cnt", ts_cnt, '0);
    checkOutput("reset_err_cfg", err_cfg, 1'b0);
    checkOutput("reset_err_tlast", err_tlast, 1'b0);
    checkQuiet("reset");
    driveStreams(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] plain 3/2/4 sequence");
    applyStimulus(3, 2, 4, 1'b0, -1, -1, -1);

    $display("[TB] random stalls on all streams");
    applyStimulus(3, 2, 4, 1'b1, -1, -1, -1);

    $display("[TB] early host tlast on beat 2");
    applyStimulus(3, 2, 4, 1'b1, 1, -1, -1);

    $display("[TB] abort in WAIT_OUT after one output beat");
    applyStimulus(3, 2, 4, 1'b0, -1, 1, -1);
    applyStimulus(3, 2, 4, 1'b1, -1, -1, -1);

    $display("[TB] zero output beats rejected");
    cfg_inp_beats = 8'd3;
    cfg_out_beats = 8'd0;
    cfg_seq_len   = 16'd4;
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    driveStreams(1'b1);
    @(negedge clk);
    checkOutput("cfg_err_set", err_cfg, 1'b1);
    checkQuiet("cfg_err");
    @(negedge clk);
    checkOutput("cfg_err_sticky", err_cfg, 1'b1);
    checkQuiet("cfg_err_stay");
    driveStreams(1'b0);
    @(posedge clk); #1;
    applyStimulus(2, 3, 3, 1'b1, -1, -1, -1);

    $display("[TB] reset mid-FEED");
    applyStimulus(3, 2, 4, 1'b1, -1, -1, 2);
    applyStimulus(1, 1, 1, 1'b0, -1, -1, -1);
    applyStimulus(4, 1, 5, 1'b1, 7, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
